// File: rtl/alu_sched_pkg.sv
// Shared ALU definitions: op codes, flag bit positions and scheduler FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_SAL  = 3'd2;
  localparam logic [2:0] OP_SAR  = 3'd3;
  localparam logic [2:0] OP_PASS = 3'd4;
  localparam logic [2:0] OP_DAA  = 3'd5;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_sched_if.sv
// Request/response bundle between the requesters, the result consumer and alu_sched.
interface alu_sched_if #(
  parameter int NREQ = 2,
  parameter int CNTW = 5,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic [3*NREQ-1:0]    req_op;
  logic [CNTW*NREQ-1:0] req_cnt;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [IDW-1:0]       resp_id;
  logic [31:0]          resp_data;
  logic [3:0]           resp_flags;

  modport master (
    output req_valid, req_a, req_b, req_op, req_cnt, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_cnt, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_flags
  );
endinterface

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first valid at or above ptr, wrapping around.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            gnt_any_o
);

  always_comb begin
    int unsigned idx;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_i) + k) % NREQ;
      if (!gnt_any_o && valid_i[idx]) begin
        gnt_any_o    = 1'b1;
        gnt_o[idx]   = 1'b1;
        gnt_idx_o    = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one external combinational ALU between NREQ requesters, with round-robin
// grant, multi-pass feedback of the result into operand A and a held response.
module alu_sched
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int CNTW = 5,
  parameter int IDW  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_sched_if.slave    bus,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  output logic [2:0]    alu_op,
  input  logic [31:0]   alu_out,
  input  logic [3:0]    alu_flags,
  output logic          busy
);

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [31:0]     acc_q, acc_d;
  logic [31:0]     breg_q, breg_d;
  logic [2:0]      opreg_q, opreg_d;
  logic [CNTW-1:0] rem_q, rem_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [3:0]      flg_q, flg_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [CNTW-1:0] cnt_sel;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .valid_i   (bus.req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign cnt_sel = bus.req_cnt[gnt_idx*CNTW +: CNTW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = EXEC;
      EXEC:    if (rem_q == CNTW'(1)) state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state; rem is loaded with at least 1 and leaves EXEC at 1, so it never wraps.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    acc_d    = acc_q;
    breg_d   = breg_q;
    opreg_d  = opreg_q;
    rem_d    = rem_q;
    id_d     = id_q;
    flg_d    = flg_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          acc_d    = bus.req_a[gnt_idx*32 +: 32];
          breg_d   = bus.req_b[gnt_idx*32 +: 32];
          opreg_d  = bus.req_op[gnt_idx*3 +: 3];
          rem_d    = (cnt_sel == '0) ? CNTW'(1) : cnt_sel;
          id_d     = gnt_idx;
          rr_ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      EXEC: begin
        acc_d = alu_out;
        flg_d = alu_flags;
        rem_d = rem_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      acc_q    <= '0;
      breg_q   <= '0;
      opreg_q  <= '0;
      rem_q    <= '0;
      id_q     <= '0;
      flg_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      acc_q    <= acc_d;
      breg_q   <= breg_d;
      opreg_q  <= opreg_d;
      rem_q    <= rem_d;
      id_q     <= id_d;
      flg_q    <= flg_d;
    end
  end

  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = 1'b0;
    bus.resp_data  = acc_q;
    bus.resp_flags = flg_q;
    bus.resp_id    = id_q;
    alu_a          = '0;
    alu_b          = '0;
    alu_op         = '0;
    busy           = (state_q != IDLE);
    case (state_q)
      IDLE: bus.req_ready = gnt;
      EXEC: begin
        alu_a  = acc_q;
        alu_b  = breg_q;
        alu_op = opreg_q;
      end
      RESP: bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
- Shares the single combinational ALU (32-bit a/b, 3-bit op, 32-bit result, 4-bit flags) between N requesters, e.g. the execute stage and the microcode/address-generation path.
- Each request can run a multi-pass operation: the ALU result is fed back into operand A for a programmed number of passes. Examples are shift-by-n built from single-step SAL/SAR, and repeated add.
- Round-robin arbitration, a valid/ready request handshake, and a registered, held response.
- The ALU itself stays an instance outside this block. alu_sched drives its inputs and samples its outputs.

Parameters:
- NREQ, 2, number of requesters (2..4).
- CNTW, 5, width of the pass-count field.
- IDW, 2, width of the response requester-id (must satisfy 2**IDW >= NREQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_a  in  32*NREQ  operand A, requester i in bits [32i+31:32i].
- req_b  in  32*NREQ  operand B, same packing.
- req_op  in  3*NREQ  ALU op code, same packing.
- req_cnt  in  CNTW*NREQ  number of ALU passes; 0 is treated as 1.
- alu_a  out  32  to ALU operand a.
- alu_b  out  32  to ALU operand b.
- alu_op  out  3  to ALU op.
- alu_out  in  32  ALU result, combinational from alu_a/alu_b/alu_op.
- alu_flags  in  4  ALU flags, combinational.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  IDW  index of the requester that owns the result.
- resp_data  out  32  final result.
- resp_flags  out  4  flags from the last pass.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: clk is the only clock. rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE, rr_ptr = 0.
  - req_ready = 0, resp_valid = 0, busy = 0.
  - resp_id = 0, resp_data = 0, resp_flags = 0.
  - alu_a/alu_b/alu_op = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant = first asserted req_valid, searching from rr_ptr upward with wrap-around.
  - req_ready[grant] = 1, combinational, IDLE only. req_ready is 0 in every other state.
  - On the grant edge, latch the request: acc <= req_a, breg <= req_b, opreg <= req_op, rem <= max(req_cnt, 1), id <= grant.
  - Also on the grant edge: rr_ptr <= (grant+1) mod NREQ, state <= EXEC.
  - No valid request: remain in IDLE, rr_ptr unchanged.
- EXEC:
  - Drive alu_a = acc, alu_b = breg, alu_op = opreg. Each cycle is one pass.
  - Each edge: acc <= alu_out, flg <= alu_flags, rem <= rem-1.
  - When rem == 1: state <= RESP.
  - Outside EXEC, alu_a/alu_b/alu_op are driven to 0.
- RESP:
  - resp_valid = 1; resp_data = acc, resp_flags = flg, resp_id = id.
  - These values are held stable until resp_ready.
  - When resp_valid && resp_ready: state <= IDLE. The next grant is possible in the following cycle, not the same cycle.
- Latency: a request accepted at edge T produces resp_valid from edge T+max(cnt,1).
- Throughput: at most one request in flight.
- Requester rules:
  - A requester must hold its valid and operands until it sees ready.
  - The block never drops a granted request.
- Max count: cnt = 2**CNTW-1 gives exactly that many passes. The rem decrement never wraps.
- Reset mid-operation (EXEC or RESP): immediately returns to reset values. The in-flight request is discarded with no response.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester that keeps its valid asserted is served within NREQ grants.
- Unknown op codes are passed to the ALU unchanged.

Decomposition:
- Shared package `alu_pkg`:
  - op code constants: OP_ADD=0, OP_OR=1, OP_SAL=2, OP_SAR=3, OP_PASS=4, OP_DAA=5.
  - flag bit indices.
  - state encodings IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- Sub-module `rr_arbiter` (NREQ): inputs valid vector and rr_ptr; outputs one-hot grant and grant index. Purely combinational; the pointer register lives in alu_sched.
- Operand muxing and the FSM stay in alu_sched.

Test Plan:
- Single pass:
  - Stimulus: req0 a=0x00000005, b=0x00000003, op=ADD, cnt=1.
  - Required: req_ready[0] pulses one cycle; resp_valid one edge later; resp_data=0x00000008, resp_id=0.
- Multi-pass feedback:
  - Stimulus: req1 a=0x00000001, b=0x00000001, op=ADD, cnt=4, with the ALU model adding.
  - Required: ALU sees a = 1,2,3,4 on successive cycles; resp_data=0x00000005 four edges after accept.
- Round-robin:
  - Stimulus: req0 and req1 both valid continuously, rr_ptr=0 after reset, resp_ready=1.
  - Required: grants in order 0,1,0,1; resp_id alternates; no requester is granted twice in a row.
- Backpressure:
  - Stimulus: resp_ready held 0 for 5 cycles after resp_valid rises.
  - Required: resp_valid, resp_data and resp_flags stay stable; req_ready stays 0 throughout; return to IDLE one edge after resp_ready=1.
- Count zero and count max:
  - Stimulus: cnt=0 with op=PASS, b=0xDEADBEEF.
  - Required: exactly 1 pass; resp_data=0xDEADBEEF.
  - Stimulus: cnt=31.
  - Required: exactly 31 EXEC cycles.
- Asynchronous reset mid-EXEC:
  - Stimulus: assert rst_n=0 between clock edges during pass 2 of 4.
  - Required: busy, resp_valid and alu_a drop to 0 without waiting for a clock edge; no response is produced after release.
